// File: rtl/fir_fold_ctrl.sv
// Folded FIR controller: one shared signed MAC walks all taps of a circular sample
// history per accepted input, with a runtime-writable coefficient file.
module fir_fold_ctrl #(
    parameter int unsigned nbtap = 8,
    parameter int unsigned dsize = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       coef_we,
    input  logic [$clog2(nbtap)-1:0]   coef_addr,
    input  logic signed [dsize-1:0]    coef_data,
    output logic                       coef_ack,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic signed [dsize-1:0]    datain,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic signed [2*dsize-1:0]  firout
);

    localparam int unsigned AW = $clog2(nbtap);
    localparam int unsigned PW = 2 * dsize;
    localparam logic [AW-1:0] KLast = AW'(nbtap - 1);

    typedef enum logic [1:0] {StIdle, StMac, StDone} state_e;

    state_e                  state_q;
    logic [AW-1:0]           k_q;
    logic [AW-1:0]           wr_ptr_q;
    logic signed [PW-1:0]    acc_q;
    logic signed [PW-1:0]    acc_d;
    logic signed [PW-1:0]    firout_q;
    logic                    out_valid_q;
    logic                    coef_ack_q;
    logic signed [dsize-1:0] delay_q [nbtap];
    logic signed [dsize-1:0] coef_q  [nbtap];

    logic [AW-1:0]           rd_idx;
    logic signed [PW-1:0]    coef_ext;
    logic signed [PW-1:0]    samp_ext;
    logic signed [PW-1:0]    prod;

    function automatic logic signed [dsize-1:0] def_coef(input int unsigned idx);
        int v;
        case (idx)
            0, 7:    v = 7;
            1, 6:    v = 14;
            2, 5:    v = -138;
            3, 4:    v = 129;
            default: v = 0;
        endcase
        return dsize'(v);
    endfunction

    // x[n-k] lives k slots behind the newest sample; AW-bit subtraction wraps mod nbtap.
    always_comb begin
        rd_idx   = wr_ptr_q - k_q;
        coef_ext = PW'(coef_q[k_q]);
        samp_ext = PW'(delay_q[rd_idx]);
        prod     = coef_ext * samp_ext;
        acc_d    = acc_q + prod;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            k_q         <= '0;
            wr_ptr_q    <= '0;
            acc_q       <= '0;
            firout_q    <= '0;
            out_valid_q <= 1'b0;
            coef_ack_q  <= 1'b0;
            for (int unsigned i = 0; i < nbtap; i++) begin
                delay_q[i] <= '0;
                coef_q[i]  <= def_coef(i);
            end
        end else begin
            coef_ack_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    // Coefficient writes only land here, so one result never mixes old and new.
                    if (coef_we) begin
                        coef_q[coef_addr] <= coef_data;
                        coef_ack_q        <= 1'b1;
                    end
                    if (in_valid) begin
                        delay_q[wr_ptr_q] <= datain;
                        acc_q             <= '0;
                        k_q               <= '0;
                        state_q           <= StMac;
                    end
                end
                StMac: begin
                    acc_q <= acc_d;
                    k_q   <= k_q + 1'b1;
                    if (k_q == KLast) begin
                        firout_q    <= acc_d;
                        out_valid_q <= 1'b1;
                        wr_ptr_q    <= wr_ptr_q + 1'b1;
                        state_q     <= StDone;
                    end
                end
                StDone: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        state_q     <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign in_ready  = (state_q == StIdle) && !rst;
    assign out_valid = out_valid_q;
    assign firout    = firout_q;
    assign coef_ack  = coef_ack_q;

endmodule

// File: tb/tb_fir_fold_ctrl.sv
// Bench for fir_fold_ctrl: directed scenarios plus randomized traffic against a
// convolution model over a queue of accepted samples.
module tb_fir_fold_ctrl;

    localparam int unsigned NBTAP = 8;
    localparam int unsigned DSIZE = 16;

    logic                      clk = 1'b0;
    logic                      rst;
    logic                      coef_we;
    logic [2:0]                coef_addr;
    logic signed [DSIZE-1:0]   coef_data;
    logic                      coef_ack;
    logic                      in_valid;
    logic                      in_ready;
    logic signed [DSIZE-1:0]   datain;
    logic                      out_valid;
    logic                      out_ready;
    logic signed [2*DSIZE-1:0] firout;

    fir_fold_ctrl #(
        .nbtap(NBTAP),
        .dsize(DSIZE)
    ) u_dut (
        .clk      (clk),
        .rst      (rst),
        .coef_we  (coef_we),
        .coef_addr(coef_addr),
        .coef_data(coef_data),
        .coef_ack (coef_ack),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .datain   (datain),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .firout   (firout)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    int hq[$];        // accepted samples, newest first
    int hm[NBTAP];    // model coefficient file

    task automatic check_val(input string tag, input longint got, input longint exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic void model_reset();
        hq.delete();
        hm = '{7, 14, -138, 129, 129, -138, 14, 7};
    endfunction

    function automatic int model_push(input int x);
        longint sum = 0;
        hq.push_front(x);
        if (hq.size() > NBTAP) void'(hq.pop_back());
        foreach (hq[k]) sum += longint'(hm[k]) * longint'(hq[k]);
        return int'(sum);
    endfunction

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk); #1;
        check_val("rst_out_valid", longint'(out_valid), 0);
        check_val("rst_firout", longint'(firout), 0);
        check_val("rst_coef_ack", longint'(coef_ack), 0);
        check_val("rst_in_ready", longint'(in_ready), 0);
        rst = 1'b0;
        model_reset();
        #1;
        check_val("post_rst_in_ready", longint'(in_ready), 1);
    endtask

    task automatic write_coef(input logic [2:0] addr, input logic signed [15:0] data);
        coef_we = 1'b1; coef_addr = addr; coef_data = data;
        @(posedge clk); #1;
        coef_we = 1'b0;
        hm[addr] = int'(data);
        check_val("coef_ack_pulse", longint'(coef_ack), 1);
        @(posedge clk); #1;
        check_val("coef_ack_drop", longint'(coef_ack), 0);
    endtask

    // Push one sample through and check result, latency, hold behaviour and handshake.
    task automatic send(input logic signed [15:0] x, input int hold, input bit bad_we,
                        input bit sim_we, input logic [2:0] sim_addr,
                        input logic signed [15:0] sim_data, output int y);
        int n;
        int exp;
        bit ack_seen;
        logic signed [31:0] held;
        in_valid = 1'b1; datain = x;
        out_ready = (hold == 0);
        if (sim_we) begin
            coef_we = 1'b1; coef_addr = sim_addr; coef_data = sim_data;
        end
        n = 0;
        while (!in_ready && n < 50) begin @(posedge clk); #1; n++; end
        if (!in_ready) check_val("accept_timeout", longint'(n), 0);
        @(posedge clk);
        if (sim_we) hm[sim_addr] = int'(sim_data);
        exp = model_push(int'(x));
        #1;
        in_valid = 1'b0; datain = 16'($urandom);
        if (sim_we) check_val("sim_coef_ack", longint'(coef_ack), 1);
        coef_we = bad_we; coef_addr = 3'($urandom); coef_data = 16'($urandom);
        ack_seen = 1'b0;
        n = 0;
        while (!out_valid && n < 100) begin
            @(posedge clk); #1; n++;
            if (coef_ack) ack_seen = 1'b1;
        end
        coef_we = 1'b0;
        check_val("latency", longint'(n), NBTAP);
        check_val("firout", longint'(firout), longint'(exp));
        check_val("in_ready_busy", longint'(in_ready), 0);
        if (bad_we) check_val("bad_we_no_ack", longint'(ack_seen), 0);
        y = int'(firout);
        if (hold > 0) begin
            held = firout;
            repeat (hold) begin
                @(posedge clk); #1;
                if (!out_valid || firout !== held || in_ready) begin
                    check_val("hold_stable", longint'(firout), longint'(held));
                    check_val("hold_valid", longint'(out_valid), 1);
                end
            end
            check_val("hold_end_valid", longint'(out_valid), 1);
            check_val("hold_end_in_ready", longint'(in_ready), 0);
            out_ready = 1'b1;
        end
        @(posedge clk); #1;
        check_val("handshake_drop", longint'(out_valid), 0);
        check_val("idle_in_ready", longint'(in_ready), 1);
        out_ready = 1'b0;
    endtask

    task automatic impulse_check(input string tag);
        int y;
        int imp[8] = '{7, 14, -138, 129, 129, -138, 14, 7};
        for (int i = 0; i < 9; i++) begin
            send((i == 0) ? 16'sd1 : 16'sd0, 0, 1'b0, 1'b0, 3'd0, 16'sd0, y);
            check_val(tag, longint'(y), (i < 8) ? longint'(imp[i]) : 0);
        end
    endtask

    initial begin
        int y;
        int cst[8] = '{700, 2100, -11700, 1200, 14100, 300, 1700, 2400};
        int seen;
        rst = 1'b1; coef_we = 1'b0; coef_addr = '0; coef_data = '0;
        in_valid = 1'b0; datain = '0; out_ready = 1'b0;
        model_reset();

        do_reset();
        impulse_check("impulse");

        do_reset();
        for (int i = 0; i < 10; i++) begin
            send(16'sd100, 0, 1'b0, 1'b0, 3'd0, 16'sd0, y);
            check_val("const100", longint'(y), longint'(cst[(i < 8) ? i : 7]));
        end

        // Long backpressure in DONE.
        send(16'sd321, 20, 1'b0, 1'b0, 3'd0, 16'sd0, y);

        do_reset();
        write_coef(3'd0, 16'sd1000);
        send(16'sd1, 0, 1'b0, 1'b0, 3'd0, 16'sd0, y);
        check_val("h0_1000", longint'(y), 1000);
        send(16'sd0, 0, 1'b1, 1'b0, 3'd0, 16'sd0, y);
        check_val("bad_we_out", longint'(y), 14);
        // Coefficient write coinciding with sample accept is used by that sample.
        send(16'sd2, 0, 1'b0, 1'b1, 3'd2, 16'sd5, y);

        do_reset();
        for (int i = 0; i < 8; i++)
            write_coef(3'(i), (i < 2) ? -16'sd32768 : 16'sd0);
        send(-16'sd32768, 0, 1'b0, 1'b0, 3'd0, 16'sd0, y);
        send(-16'sd32768, 0, 1'b0, 1'b0, 3'd0, 16'sd0, y);
        check_val("wrap", longint'(y), longint'(int'(32'h8000_0000)));

        // Reset during the third MAC cycle abandons the result.
        do_reset();
        in_valid = 1'b1; datain = 16'sd55; out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        model_reset();
        seen = 0;
        repeat (12) begin
            if (out_valid) seen++;
            @(posedge clk); #1;
        end
        check_val("abandon_no_valid", longint'(seen), 0);
        check_val("abandon_in_ready", longint'(in_ready), 1);
        out_ready = 1'b0;
        impulse_check("impulse_after_abort");

        // Randomized traffic.
        do_reset();
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 3) == 0)
                write_coef(3'($urandom), 16'($urandom));
            send(16'($urandom), int'($urandom_range(0, 3)), bit'($urandom_range(0, 1)),
                 bit'($urandom_range(0, 3) == 0), 3'($urandom), 16'($urandom), y);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
